sdl_video_pipe: RTL
===================

// Module: sdl_video_pipe
// PURPOSE
//   Parametrised video timing generator plus aligned pixel output stage, replacing fixed display_ctrl + ad-hoc SDL output regs.
//   Generates h/v counters, blanking and syncs for any mode, and delays coords/DE/syncs by the render pipeline latency.
//   Expands N-bit colour to SDL/VGA width and blanks outside the active area. Sits between renderer (graphic) and SDL/VGA pins.
// PARAMETERS
//   H_ACTIVE      800   visible pixels per line
//   H_FP          24    horizontal front porch (clocks)
//   H_SYNC        72    horizontal sync width (clocks)
//   H_BP          128   horizontal back porch (clocks); H_TOTAL = sum of H_* (default 1024)
//   V_ACTIVE      600   visible lines
//   V_FP          1     vertical front porch (lines)
//   V_SYNC        2     vertical sync width (lines)
//   V_BP          22    vertical back porch (lines); V_TOTAL = sum of V_* (default 625)
//   HS_POL        1     h_sync active level
//   VS_POL        1     v_sync active level
//   PIPE_LATENCY  2     render latency in clocks from o_h/v_coord to i_red/green/blue (0..15)
//   IN_BITS       4     colour bits per channel in
//   OUT_BITS      8     colour bits per channel out (>= IN_BITS)
// PORTS
//   pixel_clk     in   1               pixel clock
//   sim_rst       in   1               asynchronous reset, active-high
//   o_h_coord     out  HW=$clog2(H_TOTAL)  current h counter (to renderer)
//   o_v_coord     out  VW=$clog2(V_TOTAL)  current v counter (to renderer)
//   o_disp_enbl   out  1               current pixel is active (undelayed)
//   o_line_start  out  1               1-clk pulse when o_h_coord==0
//   o_frame_start out  1               1-clk pulse when o_h_coord==0 && o_v_coord==0
//   i_red/i_green/i_blue in IN_BITS    colour for coords issued PIPE_LATENCY clocks earlier
//   o_sx          out  HW              output h coord, aligned with colour
//   o_sy          out  VW              output v coord, aligned with colour
//   o_de          out  1               output display enable, aligned
//   o_h_sync      out  1               aligned h sync
//   o_v_sync      out  1               aligned v sync
//   o_red/o_green/o_blue out OUT_BITS  expanded, blanked colour
// BEHAVIOUR
//   - Reset: counters=0; delay line cleared (DE=0, syncs inactive); all outputs 0 except syncs = inactive (~HS_POL/~VS_POL).
//   - h counts 0..H_TOTAL-1 each clock; at H_TOTAL-1 wraps to 0 and v increments; v wraps at V_TOTAL-1 -> 0.
//   - o_disp_enbl = (h<H_ACTIVE)&&(v<V_ACTIVE). hsync active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC);
//     vsync active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), whole lines.
//   - o_h/v_coord, o_disp_enbl, pulses are registered counter state (valid same cycle as counter).
//   - Shift register of depth PIPE_LATENCY carries {h,v,de,hs,vs}; PIPE_LATENCY=0 means no delay stage.
//   - Final output register: total latency coord->o_* = PIPE_LATENCY+1 clocks; colours sampled same edge.
//   - Expansion: input replicated MSB-first and truncated to OUT_BITS (4->8: {c,c}; 5->8: {c,c[4:2]}).
//   - Delayed DE=0 -> o_red/o_green/o_blue forced 0 regardless of inputs.
//   - Reset mid-frame: everything returns to reset values asynchronously; first clock after release h=1,v=0 counters run from 0.
//   - Elaboration check: OUT_BITS<IN_BITS or any *_SYNC==0 or PIPE_LATENCY>15 -> $error.
// TESTING
//   1 Reset held: o_* = 0, o_h_sync=o_v_sync=0 (POL=1); release -> o_h_coord 0,1,2..., o_frame_start=1 at (0,0).
//   2 Line/frame wrap: h=1023 -> h=0,v+1; at (1023,624) -> (0,0) with o_frame_start=1; count 640000 clocks/frame.
//   3 Sync windows: o_h_sync high exactly for aligned h 824..895; o_v_sync high for lines 601..602; check PIPE_LATENCY+1 lag.
//   4 Latency: PIPE_LATENCY=2, drive i_red=4'hA when input coord was (0,0) -> 3 clocks later o_sx=0,o_sy=0,o_de=1,o_red=8'hAA.
//   5 Blanking: i_red/green/blue=4'hF held constant -> o_* = 8'hFF only while o_de=1, 0 at h>=800 or v>=600.
//   6 Small mode H=8/1/2/1, V=4/1/1/1, PIPE_LATENCY=0, IN 5/OUT 8: period 12x7, input 5'b10110 -> 8'b10110101; reset at h=5 mid-line.

Source files
------------

// File: rtl/sdl_video_pipe_if.sv
// ---------------------------------------------------------------------------
// sdl_video_pipe_if
//   Bundles every non-clock signal of sdl_video_pipe: the renderer-facing
//   timing outputs, the colour returned by the renderer, and the aligned
//   SDL/VGA pixel outputs.
//   Parameters: HW/VW are the counter widths ($clog2 of H_TOTAL/V_TOTAL of the
//   attached pipe); IN_BITS/OUT_BITS are the per-channel colour widths.
//   Modports:
//     master - the video pipe (drives o_*, receives i_red/i_green/i_blue)
//     slave  - renderer + display side (receives o_*, drives colour)
// ---------------------------------------------------------------------------
interface sdl_video_pipe_if #(
  parameter int HW       = 10,
  parameter int VW       = 10,
  parameter int IN_BITS  = 4,
  parameter int OUT_BITS = 8
);
  // renderer side, undelayed
  logic [HW-1:0]       o_h_coord;
  logic [VW-1:0]       o_v_coord;
  logic                o_disp_enbl;
  logic                o_line_start;
  logic                o_frame_start;
  // colour for coordinates issued PIPE_LATENCY clocks earlier
  logic [IN_BITS-1:0]  i_red;
  logic [IN_BITS-1:0]  i_green;
  logic [IN_BITS-1:0]  i_blue;
  // display side, aligned with colour
  logic [HW-1:0]       o_sx;
  logic [VW-1:0]       o_sy;
  logic                o_de;
  logic                o_h_sync;
  logic                o_v_sync;
  logic [OUT_BITS-1:0] o_red;
  logic [OUT_BITS-1:0] o_green;
  logic [OUT_BITS-1:0] o_blue;

  modport master (
    output o_h_coord, o_v_coord, o_disp_enbl, o_line_start, o_frame_start,
    input  i_red, i_green, i_blue,
    output o_sx, o_sy, o_de, o_h_sync, o_v_sync, o_red, o_green, o_blue
  );

  modport slave (
    input  o_h_coord, o_v_coord, o_disp_enbl, o_line_start, o_frame_start,
    output i_red, i_green, i_blue,
    input  o_sx, o_sy, o_de, o_h_sync, o_v_sync, o_red, o_green, o_blue
  );
endinterface

// File: rtl/sdl_video_pipe.sv
// ---------------------------------------------------------------------------
// sdl_video_pipe
//   Parametrised video timing generator with an aligned pixel output stage.
//   A free-running h/v counter produces coordinates, display enable, syncs and
//   line/frame pulses for the renderer. The same timing is delayed by
//   PIPE_LATENCY clocks so it lines up with the colour coming back from the
//   renderer, then one output register expands the colour to OUT_BITS and
//   blanks it outside the active area.
//   Ports:
//     pixel_clk - pixel clock
//     sim_rst   - asynchronous reset, active-high
//     vid       - sdl_video_pipe_if.master (timing, colour in, aligned out)
//   Latency: coordinate on vid.o_h/v_coord -> same pixel on vid.o_* is
//   PIPE_LATENCY+1 clocks.
// ---------------------------------------------------------------------------
module sdl_video_pipe #(
  parameter int H_ACTIVE     = 800,
  parameter int H_FP         = 24,
  parameter int H_SYNC       = 72,
  parameter int H_BP         = 128,
  parameter int V_ACTIVE     = 600,
  parameter int V_FP         = 1,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 22,
  parameter int HS_POL       = 1,
  parameter int VS_POL       = 1,
  parameter int PIPE_LATENCY = 2,
  parameter int IN_BITS      = 4,
  parameter int OUT_BITS     = 8
) (
  input  logic                  pixel_clk,
  input  logic                  sim_rst,
  sdl_video_pipe_if.master      vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  // Window bounds kept 32-bit unsigned so a bound equal to H_TOTAL still fits.
  localparam logic [31:0] H_ACT_END = 32'(H_ACTIVE);
  localparam logic [31:0] HS_START  = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END    = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] V_ACT_END = 32'(V_ACTIVE);
  localparam logic [31:0] VS_START  = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END    = 32'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  if (OUT_BITS < IN_BITS || H_SYNC == 0 || V_SYNC == 0 ||
      PIPE_LATENCY < 0 || PIPE_LATENCY > 15) begin : g_bad_params
    $error("sdl_video_pipe: illegal parameter combination");
  end

  typedef struct packed {
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          de;
    logic          hs;
    logic          vs;
  } tap_t;

  localparam tap_t TAP_RST = '{h: '0, v: '0, de: 1'b0, hs: ~HS_ACT, vs: ~VS_ACT};

  // Replicate the input code MSB-first until OUT_BITS are filled, so full
  // scale maps to full scale (4'hF -> 8'hFF) and zero stays zero.
  function automatic logic [OUT_BITS-1:0] expand(input logic [IN_BITS-1:0] c);
    logic [OUT_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < OUT_BITS; i++) begin
      r[OUT_BITS-1-i] = c[IN_BITS-1-(i % IN_BITS)];
    end
    return r;
  endfunction

  logic [HW-1:0] h_p0;
  logic [VW-1:0] v_p0;
  logic          de_p0;
  logic          hs_p0;
  logic          vs_p0;
  logic          ls_p0;
  logic          fs_p0;

  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;
  logic [31:0]   h_nxt32;
  logic [31:0]   v_nxt32;

  always_comb begin
    h_nxt = h_p0 + HW'(1);
    v_nxt = v_p0;
    if (h_p0 == HW'(H_TOTAL - 1)) begin
      h_nxt = '0;
      v_nxt = (v_p0 == VW'(V_TOTAL - 1)) ? '0 : v_p0 + VW'(1);
    end
    h_nxt32 = 32'(h_nxt);
    v_nxt32 = 32'(v_nxt);
  end

  // ---- stage p0: counters plus flags decoded from the next count ----
  // Flags are registered alongside the counters so they stay 0 while reset is
  // held, even though the counters themselves sit at (0,0).
  always_ff @(posedge pixel_clk or posedge sim_rst) begin
    if (sim_rst) begin
      h_p0  <= '0;
      v_p0  <= '0;
      de_p0 <= 1'b0;
      ls_p0 <= 1'b0;
      fs_p0 <= 1'b0;
      hs_p0 <= ~HS_ACT;
      vs_p0 <= ~VS_ACT;
    end else begin
      h_p0  <= h_nxt;
      v_p0  <= v_nxt;
      de_p0 <= (h_nxt32 < H_ACT_END) && (v_nxt32 < V_ACT_END);
      ls_p0 <= (h_nxt == '0);
      fs_p0 <= (h_nxt == '0) && (v_nxt == '0);
      hs_p0 <= ((h_nxt32 >= HS_START) && (h_nxt32 < HS_END)) ? HS_ACT : ~HS_ACT;
      vs_p0 <= ((v_nxt32 >= VS_START) && (v_nxt32 < VS_END)) ? VS_ACT : ~VS_ACT;
    end
  end

  assign vid.o_h_coord     = h_p0;
  assign vid.o_v_coord     = v_p0;
  assign vid.o_disp_enbl   = de_p0;
  assign vid.o_line_start  = ls_p0;
  assign vid.o_frame_start = fs_p0;

  tap_t cur_p0;
  tap_t tail_p1;

  assign cur_p0 = {h_p0, v_p0, de_p0, hs_p0, vs_p0};

  // ---- stage p1: PIPE_LATENCY-deep delay matching the renderer ----
  if (PIPE_LATENCY == 0) begin : g_no_delay
    assign tail_p1 = cur_p0;
  end else begin : g_delay
    tap_t dly_p1 [PIPE_LATENCY];

    always_ff @(posedge pixel_clk or posedge sim_rst) begin
      if (sim_rst) begin
        for (int i = 0; i < PIPE_LATENCY; i++) dly_p1[i] <= TAP_RST;
      end else begin
        dly_p1[0] <= cur_p0;
        for (int i = 1; i < PIPE_LATENCY; i++) dly_p1[i] <= dly_p1[i-1];
      end
    end

    assign tail_p1 = dly_p1[PIPE_LATENCY-1];
  end

  // ---- stage p2: output register, colour sampled on the same edge ----
  always_ff @(posedge pixel_clk or posedge sim_rst) begin
    if (sim_rst) begin
      vid.o_sx     <= '0;
      vid.o_sy     <= '0;
      vid.o_de     <= 1'b0;
      vid.o_h_sync <= ~HS_ACT;
      vid.o_v_sync <= ~VS_ACT;
      vid.o_red    <= '0;
      vid.o_green  <= '0;
      vid.o_blue   <= '0;
    end else begin
      vid.o_sx     <= tail_p1.h;
      vid.o_sy     <= tail_p1.v;
      vid.o_de     <= tail_p1.de;
      vid.o_h_sync <= tail_p1.hs;
      vid.o_v_sync <= tail_p1.vs;
      vid.o_red    <= tail_p1.de ? expand(vid.i_red)   : '0;
      vid.o_green  <= tail_p1.de ? expand(vid.i_green) : '0;
      vid.o_blue   <= tail_p1.de ? expand(vid.i_blue)  : '0;
    end
  end

endmodule
